// File: rtl/bird_sprite_drawer_if.sv
// Scan-side, ROM and output signals of the bird sprite drawer.
// The slave modport is the drawer's view. The master modport is the view of the surrounding video path and the ROM.
interface bird_sprite_drawer_if;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        video_on;
  logic        hsync_in;
  logic        vsync_in;
  logic [11:0] bg_rgb;
  logic        pipe_px;
  logic        frame_tick;
  logic [9:0]  bird_y_in;
  logic [4:0]  rom_row;
  logic [4:0]  rom_col;
  logic [11:0] rom_pixel;
  logic [11:0] rgb_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        collision;

  modport slave (
    input  x, y, video_on, hsync_in, vsync_in, bg_rgb, pipe_px,
    input  frame_tick, bird_y_in, rom_pixel,
    output rom_row, rom_col, rgb_out, hsync_out, vsync_out, collision
  );

  modport master (
    output x, y, video_on, hsync_in, vsync_in, bg_rgb, pipe_px,
    output frame_tick, bird_y_in, rom_pixel,
    input  rom_row, rom_col, rgb_out, hsync_out, vsync_out, collision
  );
endinterface

// File: rtl/bird_sprite_drawer.sv
// Composites the 24x24 bird sprite over the background through a fixed 3-clock pipeline.
// It also flags any bird/pipe overlap for each frame.
module bird_sprite_drawer #(
  parameter int          SPRITE_W  = 24,
  parameter int          SPRITE_H  = 24,
  parameter int          BIRD_X    = 160,
  parameter logic [11:0] KEY_COLOR = 12'hF0F,
  parameter int          RESET_Y   = 240
) (
  input  logic               clk,
  input  logic               reset,
  bird_sprite_drawer_if.slave bus
);

  localparam logic [10:0] X_LO  = 11'(BIRD_X);
  localparam logic [10:0] X_HI  = 11'(BIRD_X + SPRITE_W);
  localparam logic [10:0] H_EXT = 11'(SPRITE_H);
  localparam logic [4:0]  X_LO5 = X_LO[4:0];

  logic [9:0]  r_bird_y_lat;
  logic [4:0]  r_rom_row, r_rom_col;
  logic        r_hit1, r_von1, r_hs1, r_vs1, r_pipe1;
  logic [11:0] r_bg1;
  logic        r_hit2, r_von2, r_hs2, r_vs2, r_pipe2;
  logic [11:0] r_bg2;
  logic [11:0] r_rgb;
  logic        r_hs3, r_vs3, r_collision;

  logic [10:0] w_x11, w_y11, w_top11, w_bot11;
  logic        w_hit, w_opaque;
  logic [4:0]  w_row, w_col;

  // 11-bit compares so that bird_y_lat + SPRITE_H cannot wrap past row 1023.
  always_comb begin
    w_x11   = {1'b0, bus.x};
    w_y11   = {1'b0, bus.y};
    w_top11 = {1'b0, r_bird_y_lat};
    w_bot11 = w_top11 + H_EXT;
    w_hit   = bus.video_on && (w_x11 >= X_LO) && (w_x11 < X_HI) &&
              (w_y11 >= w_top11) && (w_y11 < w_bot11);
    // The low 5 bits of a difference depend only on the low 5 bits of its operands.
    w_row   = bus.y[4:0] - r_bird_y_lat[4:0];
    w_col   = bus.x[4:0] - X_LO5;
    w_opaque = r_hit2 && (bus.rom_pixel != KEY_COLOR);
  end

  // NOTE: every register in this block uses a non-blocking assignment.
  // All pipeline stages then sample the values that were present before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bird_y_lat <= 10'(RESET_Y);
      r_rom_row    <= '0;
      r_rom_col    <= '0;
      r_hit1       <= 1'b0;
      r_von1       <= 1'b0;
      r_hs1        <= 1'b1;
      r_vs1        <= 1'b1;
      r_pipe1      <= 1'b0;
      r_bg1        <= '0;
      r_hit2       <= 1'b0;
      r_von2       <= 1'b0;
      r_hs2        <= 1'b1;
      r_vs2        <= 1'b1;
      r_pipe2      <= 1'b0;
      r_bg2        <= '0;
      r_rgb        <= '0;
      r_hs3        <= 1'b1;
      r_vs3        <= 1'b1;
      r_collision  <= 1'b0;
    end else begin
      // The bird moves only during vertical blanking, so a frame never tears.
      if (bus.frame_tick) r_bird_y_lat <= bus.bird_y_in;

      r_rom_row <= w_hit ? w_row : 5'd0;
      r_rom_col <= w_hit ? w_col : 5'd0;
      r_hit1    <= w_hit;
      r_von1    <= bus.video_on;
      r_hs1     <= bus.hsync_in;
      r_vs1     <= bus.vsync_in;
      r_pipe1   <= bus.pipe_px;
      r_bg1     <= bus.bg_rgb;

      r_hit2    <= r_hit1;
      r_von2    <= r_von1;
      r_hs2     <= r_hs1;
      r_vs2     <= r_vs1;
      r_pipe2   <= r_pipe1;
      r_bg2     <= r_bg1;

      r_rgb     <= !r_von2 ? 12'h000 : (w_opaque ? bus.rom_pixel : r_bg2);
      r_hs3     <= r_hs2;
      r_vs3     <= r_vs2;

      // A set takes priority over a frame_tick clear on the same edge.
      if (w_opaque && r_pipe2)  r_collision <= 1'b1;
      else if (bus.frame_tick)  r_collision <= 1'b0;
    end
  end

  assign bus.rom_row   = r_rom_row;
  assign bus.rom_col   = r_rom_col;
  assign bus.rgb_out   = r_rgb;
  assign bus.hsync_out = r_hs3;
  assign bus.vsync_out = r_vs3;
  assign bus.collision = r_collision;

endmodule

// File: tb/tb_bird_sprite_drawer.sv
// Directed bench for bird_sprite_drawer with a registered 1-clock ROM model.
// It uses table-driven pixel vectors plus hand-written sequences for the latch, collision, sync and reset cases.
module tb_bird_sprite_drawer;
  logic clk = 1'b0;
  logic reset;
  logic rom_key;
  int   n_checks = 0;
  int   n_pass   = 0;

  bird_sprite_drawer_if bus ();

  bird_sprite_drawer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // The ROM returns all 12'hFF0, or the key colour everywhere when rom_key is set.
  always @(posedge clk) bus.rom_pixel <= rom_key ? 12'hF0F : 12'hFF0;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        von;
    logic [11:0] bg;
    logic        pipe;
    logic [4:0]  exp_row;
    logic [4:0]  exp_col;
    logic [11:0] exp_rgb;
  } vec_t;

  vec_t tbl_a[9];
  vec_t tbl_b[3];

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle();
    bus.x = '0; bus.y = '0; bus.video_on = 1'b0; bus.bg_rgb = '0; bus.pipe_px = 1'b0;
    bus.hsync_in = 1'b1; bus.vsync_in = 1'b1; bus.frame_tick = 1'b0;
  endtask

  task automatic drive_px(input logic [9:0] x, input logic [9:0] y, input logic von,
                          input logic [11:0] bg, input logic pipe);
    bus.x = x; bus.y = y; bus.video_on = von; bus.bg_rgb = bg; bus.pipe_px = pipe;
  endtask

  // One pixel: the ROM address is checked after edge 1 and rgb_out after edge 3.
  task automatic run_pixel(input vec_t v, input string tag);
    @(negedge clk);
    drive_px(v.x, v.y, v.von, v.bg, v.pipe);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_row"}, 12'(bus.rom_row), 12'(v.exp_row));
    check({tag, "_col"}, 12'(bus.rom_col), 12'(v.exp_col));
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({tag, "_rgb"}, bus.rgb_out, v.exp_rgb);
  endtask

  initial begin
    logic [15:0] hp, vp;
    //            x    y    von  bg       pipe row   col   rgb
    tbl_a[0] = '{10'd160, 10'd240, 1'b1, 12'h00F, 1'b0, 5'd0,  5'd0,  12'hFF0};
    tbl_a[1] = '{10'd159, 10'd250, 1'b1, 12'h00F, 1'b0, 5'd0,  5'd0,  12'h00F};
    tbl_a[2] = '{10'd184, 10'd250, 1'b1, 12'h00F, 1'b0, 5'd0,  5'd0,  12'h00F};
    tbl_a[3] = '{10'd183, 10'd250, 1'b1, 12'h00F, 1'b0, 5'd10, 5'd23, 12'hFF0};
    tbl_a[4] = '{10'd170, 10'd263, 1'b1, 12'h00F, 1'b0, 5'd23, 5'd10, 12'hFF0};
    tbl_a[5] = '{10'd170, 10'd264, 1'b1, 12'h00F, 1'b0, 5'd0,  5'd0,  12'h00F};
    tbl_a[6] = '{10'd170, 10'd239, 1'b1, 12'h00F, 1'b0, 5'd0,  5'd0,  12'h00F};
    tbl_a[7] = '{10'd170, 10'd245, 1'b0, 12'h123, 1'b1, 5'd0,  5'd0,  12'h000};
    tbl_a[8] = '{10'd0,   10'd0,   1'b1, 12'hABC, 1'b0, 5'd0,  5'd0,  12'hABC};
    // These vectors apply after the bird has moved to row 100.
    tbl_b[0] = '{10'd160, 10'd100, 1'b1, 12'h00F, 1'b0, 5'd0,  5'd0,  12'hFF0};
    tbl_b[1] = '{10'd165, 10'd123, 1'b1, 12'h00F, 1'b0, 5'd23, 5'd5,  12'hFF0};
    tbl_b[2] = '{10'd160, 10'd240, 1'b1, 12'h00F, 1'b0, 5'd0,  5'd0,  12'h00F};

    rom_key = 1'b0;
    idle();
    bus.bird_y_in = 10'd240;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rgb", bus.rgb_out, 12'h000);
    check("rst_hs", 12'(bus.hsync_out), 12'h1);
    check("rst_vs", 12'(bus.vsync_out), 12'h1);
    check("rst_row", 12'(bus.rom_row), 12'h0);
    check("rst_col", 12'(bus.rom_col), 12'h0);
    check("rst_coll", 12'(bus.collision), 12'h0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) run_pixel(tbl_a[i], $sformatf("a%0d", i));

    // A new bird_y_in without frame_tick leaves the bird at row 240.
    bus.bird_y_in = 10'd100;
    run_pixel(tbl_a[0], "nolatch_240");
    run_pixel('{10'd160, 10'd100, 1'b1, 12'h00F, 1'b0, 5'd0, 5'd0, 12'h00F}, "nolatch_100");
    @(negedge clk);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    for (int i = 0; i < 3; i++) run_pixel(tbl_b[i], $sformatf("b%0d", i));

    // A key-colour pixel over a pipe shows the background and does not collide.
    rom_key = 1'b1;
    run_pixel('{10'd165, 10'd105, 1'b1, 12'h00F, 1'b1, 5'd5, 5'd5, 12'h00F}, "key");
    check("key_coll", 12'(bus.collision), 12'h0);
    rom_key = 1'b0;

    // An opaque pixel without a pipe does not collide.
    run_pixel('{10'd165, 10'd105, 1'b1, 12'h00F, 1'b0, 5'd5, 5'd5, 12'hFF0}, "nopipe");
    check("nopipe_coll", 12'(bus.collision), 12'h0);

    // An opaque pixel over a pipe sets the flag, and the flag then holds.
    run_pixel('{10'd165, 10'd105, 1'b1, 12'h00F, 1'b1, 5'd5, 5'd5, 12'hFF0}, "hit");
    check("hit_coll", 12'(bus.collision), 12'h1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("hold_coll", 12'(bus.collision), 12'h1);
    bus.frame_tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.frame_tick = 1'b0;
    check("tick_clear", 12'(bus.collision), 12'h0);

    // A set coinciding with frame_tick on edge 3 leaves the flag set.
    drive_px(10'd165, 10'd105, 1'b1, 12'h00F, 1'b1);
    @(posedge clk);
    @(negedge clk);
    idle();
    @(posedge clk);
    @(negedge clk);
    check("pre_coinc_coll", 12'(bus.collision), 12'h0);
    bus.frame_tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.frame_tick = 1'b0;
    check("coinc_coll", 12'(bus.collision), 12'h1);
    check("coinc_rgb", bus.rgb_out, 12'hFF0);

    // Each sync output equals its input three clocks earlier.
    hp = 16'b1011_0011_1001_0110;
    vp = 16'b0110_1101_0011_1010;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check($sformatf("hs_%0d", k), 12'(bus.hsync_out), 12'(k >= 3 ? hp[k-3] : 1'b1));
      check($sformatf("vs_%0d", k), 12'(bus.vsync_out), 12'(k >= 3 ? vp[k-3] : 1'b1));
      bus.hsync_in = hp[k];
      bus.vsync_in = vp[k];
    end
    @(negedge clk);
    idle();
    repeat (4) @(posedge clk);

    // A mid-line reset clears the whole pipeline and returns the bird to row 240.
    @(negedge clk);
    drive_px(10'd160, 10'd100, 1'b1, 12'h00F, 1'b1);
    bus.hsync_in = 1'b0;
    bus.vsync_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_rst_rgb", bus.rgb_out, 12'hFF0);
    check("pre_rst_hs", 12'(bus.hsync_out), 12'h0);
    check("pre_rst_coll", 12'(bus.collision), 12'h1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_rgb", bus.rgb_out, 12'h000);
    check("mid_rst_hs", 12'(bus.hsync_out), 12'h1);
    check("mid_rst_vs", 12'(bus.vsync_out), 12'h1);
    check("mid_rst_coll", 12'(bus.collision), 12'h0);
    check("mid_rst_row", 12'(bus.rom_row), 12'h0);
    check("mid_rst_col", 12'(bus.rom_col), 12'h0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("post_rst_rgb", bus.rgb_out, 12'h00F);
    check("post_rst_hs", 12'(bus.hsync_out), 12'h0);
    check("post_rst_vs", 12'(bus.vsync_out), 12'h0);
    check("post_rst_coll", 12'(bus.collision), 12'h0);
    idle();
    run_pixel(tbl_a[0], "post_rst_top240");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/bird_sprite_drawer.md
Name: bird_sprite_drawer

Overview:
Pixel-pipeline client of the 24x24 bird sprite ROM (row/col in, 12-bit pixel out one clock later).
- Takes the VGA scan position and the bird's vertical position.
- Drives the ROM row/col address and consumes the returned pixel.
- Composites the sprite over the incoming background colour, delaying syncs to match.
- Raises a per-frame sticky collision flag when an opaque bird pixel lands on a pipe pixel.
- Sits between the VGA timing generator and the RGB output register.

Parameters:
- SPRITE_W, 24, sprite width in pixels.
- SPRITE_H, 24, sprite height in pixels.
- BIRD_X, 160, fixed left screen column of the sprite.
- KEY_COLOR, 12'hF0F, ROM colour treated as transparent.
- RESET_Y, 240, bird top row loaded at reset.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- x, input, 10, current scan column.
- y, input, 10, current scan row.
- video_on, input, 1, active-video flag.
- hsync_in, input, 1, horizontal sync, undelayed.
- vsync_in, input, 1, vertical sync, undelayed.
- bg_rgb, input, 12, background colour for this pixel.
- pipe_px, input, 1, this pixel belongs to a pipe.
- frame_tick, input, 1, one-cycle pulse in vertical blanking.
- bird_y_in, input, 10, requested bird top row.
- rom_row, output, 5, ROM row address.
- rom_col, output, 5, ROM column address.
- rom_pixel, input, 12, ROM data, valid one clk after the address.
- rgb_out, output, 12, composited colour.
- hsync_out, output, 1, delayed hsync.
- vsync_out, output, 1, delayed vsync.
- collision, output, 1, sticky bird/pipe overlap flag for the current frame.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values:
  - rgb_out = 0.
  - hsync_out = 1, vsync_out = 1 (idle-high syncs).
  - rom_row = rom_col = 0.
  - collision = 0.
  - bird_y latch = RESET_Y.
  - All pipeline valid/hit bits = 0.
- Reset asserted mid-frame clears the whole pipeline on the next edge. Output resumes correct values 3 clks after reset deasserts.
- Position latch: bird_y_lat <= bird_y_in only on a cycle with frame_tick = 1, so there is no mid-frame tearing. bird_y_in is ignored otherwise.
- Hit test at stage 0, combinational on the inputs, all arithmetic 11-bit unsigned (no wrap):
  - hit = video_on && x >= BIRD_X && x < BIRD_X+SPRITE_W && y >= bird_y_lat && y < bird_y_lat+SPRITE_H.
  - If bird_y_lat+SPRITE_H > 479, the rows past the screen are simply never scanned (natural clip).
- Stage 1 (edge 1):
  - rom_row <= y - bird_y_lat and rom_col <= x - BIRD_X, low 5 bits, when hit. Otherwise both <= 0.
  - Register hit1, video_on, syncs, bg_rgb, pipe_px.
- Stage 2 (edge 2): ROM returns rom_pixel for stage-1 address. Shift hit2 and the side-band signals.
- Stage 3 (edge 3):
  - opaque = hit2 && rom_pixel != KEY_COLOR.
  - rgb_out <= !video_on2 ? 0 : opaque ? rom_pixel : bg_rgb2.
  - hsync_out/vsync_out <= stage-2 copies.
- Total latency from x/y/syncs to rgb_out/syncs: exactly 3 clks, fixed, including when hit = 0.
- Collision:
  - Set on edge 3 when opaque && pipe_px2.
  - Cleared on frame_tick.
  - If frame_tick and a set condition occur on the same edge, set wins.
  - Holds its value otherwise.
- Pixels with video_on low never hit, never set collision, and output 0.

Test Plan:
1. Reset, then x=160, y=240, video_on=1, bg=12'h00F, ROM all 12'hFF0 -> rom_row=0, rom_col=0 after 1 clk; rgb_out=12'hFF0 exactly 3 clks after input.
2. Scan x=159 and x=184 on y=250 -> rgb_out = bg 12'h00F for both; x=183 -> 12'hFF0 with rom_col=23, rom_row=10.
3. Set bird_y_in=100 without frame_tick -> sprite still drawn at rows 240..263; pulse frame_tick -> next frame draws at rows 100..123, y=100 gives rom_row=0.
4. ROM returns KEY_COLOR 12'hF0F at an in-box pixel -> rgb_out = bg_rgb; collision stays 0 even with pipe_px=1.
5. Opaque bird pixel with pipe_px=1 -> collision=1 from edge 3 and stays 1 through the frame; frame_tick alone clears it; frame_tick coincident with a new set -> collision stays 1.
6. Toggle hsync_in/vsync_in, and assert reset mid-line -> syncs appear 3 clks delayed; reset gives rgb_out=0, syncs=1, collision=0, bird top at row 240.
